// File: rtl/diff_recover_pkg.sv
// Shared types and sizing helpers for the chunked subtract-with-borrow
// recovery datapath (sum - a, CHUNK_WIDTH bits per cycle).
package diff_recover_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Number of slices needed to cover the (w+1)-bit sum.
  function automatic int unsigned calc_nchunk(input int unsigned w,
                                              input int unsigned cw);
    return (w + 1 + cw - 1) / cw;
  endfunction

endpackage

// File: rtl/diff_recover_chunk.sv
// Combinational CHUNK-wide subtract-with-borrow: {bout, d} = x - y - bin.
module diff_chunk_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  logic [WIDTH:0] res;

  always_comb begin
    res  = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bin};
    d    = res[WIDTH-1:0];
    bout = res[WIDTH];
  end

endmodule

// File: rtl/diff_recover.sv
// Recovers addend b from an adder result: b = (sum - a)[W-1:0], processed
// one CHUNK_WIDTH slice per cycle through a single shared subtractor.
module diff_recover
  import diff_recover_pkg::*;
#(
  parameter int unsigned ADDER_WIDTH = 39,
  parameter int unsigned CHUNK_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDER_WIDTH:0]   sum,
  input  logic [ADDER_WIDTH-1:0] a,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDER_WIDTH-1:0] b,
  output logic                   err
);

  localparam int unsigned W      = ADDER_WIDTH;
  localparam int unsigned SW     = W + 1;
  localparam int unsigned NCHUNK = calc_nchunk(W, CHUNK_WIDTH);
  localparam int unsigned PW     = NCHUNK * CHUNK_WIDTH;
  localparam int unsigned CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NCHUNK - 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [W-1:0]    a_q, a_d;
  logic [SW-1:0]   diff_q, diff_d;
  logic            borrow_q, borrow_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    b_q, b_d;
  logic            err_q, err_d;

  logic [PW-1:0]          sum_pad, a_pad, diff_pad, slice_mask;
  logic [31:0]            shamt;
  logic [CHUNK_WIDTH-1:0] x_slice, y_slice, d_slice;
  logic                   bout;

  // Operands are zero-padded to a whole number of slices; the padding above
  // bit W is zero in both, so the slice borrow equals the borrow out of bit W.
  always_comb begin
    shamt      = 32'(cnt_q) * CHUNK_WIDTH;
    sum_pad    = PW'(sum_q);
    a_pad      = PW'(a_q);
    slice_mask = PW'({CHUNK_WIDTH{1'b1}});
    x_slice    = CHUNK_WIDTH'(sum_pad >> shamt);
    y_slice    = CHUNK_WIDTH'(a_pad >> shamt);
  end

  diff_chunk_sub #(
    .WIDTH (CHUNK_WIDTH)
  ) u_sub (
    .x    (x_slice),
    .y    (y_slice),
    .bin  (borrow_q),
    .d    (d_slice),
    .bout (bout)
  );

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    a_d      = a_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    err_d    = err_q;
    diff_pad = (PW'(diff_q) & ~(slice_mask << shamt)) | (PW'(d_slice) << shamt);

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sum_d    = sum;
          a_d      = a;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d   = diff_pad[SW-1:0];
        borrow_d = bout;
        if (cnt_q == CNT_LAST) begin
          b_d     = diff_d[W-1:0];
          err_d   = bout | diff_d[W];
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sum_q    <= '0;
      a_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      b_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      a_q      <= a_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign b         = b_q;
  assign err       = err_q;

endmodule

// File: tb/tb_diff_recover.sv
// Self-checking bench for diff_recover: directed vector table, reset corner
// cases, and randomized operands against an arithmetic reference model.
module tb_diff_recover;

  localparam int unsigned W      = 39;
  localparam int unsigned NCHUNK = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W:0]    sum;
  logic [W-1:0]  a;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  b;
  logic          err;

  int checks;
  int errors;

  diff_recover #(
    .ADDER_WIDTH (W),
    .CHUNK_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W:0]   s;
    logic [W-1:0] av;
    logic [W-1:0] eb;
    logic         ee;
    int           hold;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: true integer difference; err when it is negative or >= 2^W.
  function automatic logic [W:0] model(input logic [W:0] s, input logic [W-1:0] av);
    longint d;
    logic [W:0] r;
    d = longint'({24'd0, s}) - longint'({25'd0, av});
    r[W-1:0] = d[W-1:0];
    r[W]     = (d < 0) || (d > longint'(39'h7F_FFFF_FFFF));
    return r;
  endfunction

  // Called just after the accepting edge; waits for the result and retires it.
  task automatic finish_op(input logic [W-1:0] eb, input logic ee, input int hold);
    int lat;
    bit seen;
    logic [W-1:0] b0;
    logic e0;
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
      else chk("in_ready_busy", in_ready, 1'b0);
    end
    out_ready = 1'b0;
    chk("latency", lat, NCHUNK + 1);
    chk("b", b, eb);
    chk("err", err, ee);
    b0 = b;
    e0 = err;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      sum      = 40'({$urandom, $urandom});
      a        = 39'({$urandom, $urandom});
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_b", b, b0);
      chk("hold_err", err, e0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("ret_in_ready", in_ready, 1'b1);
    chk("ret_out_valid", out_valid, 1'b0);
  endtask

  task automatic run_op(input logic [W:0] s, input logic [W-1:0] av,
                        input logic [W-1:0] eb, input logic ee, input int hold);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    sum      = s;
    a        = av;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sum      = 40'({$urandom, $urandom});
    a        = 39'({$urandom, $urandom});
    finish_op(eb, ee, hold);
  endtask

  vec_t tbl[7];
  logic [W:0]   rs, exp_r;
  logic [W-1:0] ra;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum       = '0;
    a         = '0;

    tbl[0] = '{40'd100,          39'd58,             39'd42,             1'b0, 0};
    tbl[1] = '{40'd5,            39'd7,              39'h7F_FFFF_FFFE,   1'b1, 10};
    tbl[2] = '{40'hFF_FFFF_FFFF, 39'h7F_FFFF_FFFF,   39'd0,              1'b1, 0};
    tbl[3] = '{40'hFF_FFFF_FFFE, 39'h7F_FFFF_FFFF,   39'h7F_FFFF_FFFF,   1'b0, 2};
    tbl[4] = '{40'd0,            39'd0,              39'd0,              1'b0, 0};
    tbl[5] = '{40'h80_0000_0000, 39'd0,              39'd0,              1'b1, 1};
    tbl[6] = '{40'h7F_FFFF_FFFF, 39'd1,              39'h7F_FFFF_FFFE,   1'b0, 0};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_b", b, '0);
    chk("rst_err", err, 1'b0);

    // Release reset and accept on the very first rising edge.
    rst_n    = 1'b1;
    in_valid = 1'b1;
    sum      = 40'd100;
    a        = 39'd58;
    #1 chk("rel_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    finish_op(39'd42, 1'b0, 0);

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].s, tbl[i].av, tbl[i].eb, tbl[i].ee, tbl[i].hold);
    end

    // Reset three cycles into RUN discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    sum      = 40'd100;
    a        = 39'd58;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_b", b, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1'b0);
    end
    run_op(40'd1, 39'd1, 39'd0, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      ra = 39'({$urandom, $urandom});
      case ($urandom_range(0, 3))
        0: rs = 40'({$urandom, $urandom});
        1: rs = 40'(ra) + 40'($urandom_range(0, 3));
        2: rs = 40'(ra) - 40'd1;
        default: rs = 40'(ra) + 40'h80_0000_0000 - 40'($urandom_range(0, 1));
      endcase
      exp_r = model(rs, ra);
      run_op(rs, ra, exp_r[W-1:0], exp_r[W], $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
